dstack_regfile: RTL and testbench

//  Parametrised data-stack register file for the core. It holds DEPTH words, with

---
 rtl/dstack_regfile.sv | 142 ++++++++++++++
 tb/tb_dstack_regfile.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dstack_regfile.sv
// rtl/dstack_regfile.sv - data-stack register file with push/pop/pop2/rotate moves
// Define DSTACK_OCCUPANCY_EN to enable depth tracking and overflow/underflow pulses.
module dstack_regfile #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 32,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halt,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [ADDR_WIDTH-1:0] rotate_addr,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [1:0] MOVE_HOLD = 2'b00;
    localparam logic [1:0] MOVE_PUSH = 2'b01;
    localparam logic [1:0] MOVE_POP  = 2'b10;
    localparam logic [1:0] MOVE_POP2 = 2'b11;

    logic [WORD_WIDTH-1:0] s     [DEPTH];
    logic [WORD_WIDTH-1:0] s_nxt [DEPTH];

    // Entry 0 always takes next_top; the movement only decides how the rest shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s_nxt[i] = s[i];
        end
        s_nxt[0] = next_top;
        case (movement)
            MOVE_PUSH: begin
                for (int i = 1; i < DEPTH; i++) begin
                    s_nxt[i] = s[i-1];
                end
            end
            MOVE_POP: begin
                for (int i = 1; i < DEPTH - 1; i++) begin
                    s_nxt[i] = s[i+1];
                end
                s_nxt[DEPTH-1] = '0;
            end
            MOVE_POP2: begin
                for (int i = 1; i < DEPTH - 2; i++) begin
                    s_nxt[i] = s[i+2];
                end
                s_nxt[DEPTH-2] = '0;
                s_nxt[DEPTH-1] = '0;
            end
            default: begin
                if (rotate) begin
                    for (int i = 1; i < DEPTH; i++) begin
                        if (i <= int'(rotate_addr)) begin
                            s_nxt[i] = s[i-1];
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= '0;
            end
        end else if (!halt) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= s_nxt[i];
            end
        end
    end

    assign top          = s[0];
    assign second       = s[1];
    assign third        = s[2];
    assign rotate_value = s[rotate_addr];

`ifdef DSTACK_OCCUPANCY_EN
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] TWO  = (ADDR_WIDTH+1)'(2);

    logic [ADDR_WIDTH:0] depth_q;
    logic                overflow_q;
    logic                underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            if (!halt) begin
                case (movement)
                    MOVE_PUSH: begin
                        if (depth_q == FULL) overflow_q <= 1'b1;
                        else                 depth_q    <= depth_q + ONE;
                    end
                    MOVE_POP: begin
                        if (depth_q < ONE) underflow_q <= 1'b1;
                        else               depth_q     <= depth_q - ONE;
                    end
                    MOVE_POP2: begin
                        if (depth_q < TWO) begin
                            underflow_q <= 1'b1;
                            depth_q     <= '0;
                        end else begin
                            depth_q <= depth_q - TWO;
                        end
                    end
                    default: begin
                        // Rotating from an empty slot is reported, but the move still happens.
                        if (rotate && ({1'b0, rotate_addr} >= depth_q) &&
                            ((depth_q != '0) || (rotate_addr != '0))) begin
                            underflow_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign depth     = '0;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dstack_regfile.sv
// tb/tb_dstack_regfile.sv - randomized and directed check of dstack_regfile against a queue model
module tb_dstack_regfile;

    localparam int WW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          halt = 1'b0;
    logic [1:0]    movement = 2'b00;
    logic [WW-1:0] next_top = '0;
    logic          rotate = 1'b0;
    logic [AW-1:0] rotate_addr = '0;
    logic [WW-1:0] top, second, third, rotate_value;
    logic [AW:0]   depth;
    logic          overflow, underflow;

    dstack_regfile #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .halt(halt), .movement(movement),
        .next_top(next_top), .rotate(rotate), .rotate_addr(rotate_addr),
        .top(top), .second(second), .third(third), .rotate_value(rotate_value),
        .depth(depth), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference: the stack as a queue, element 0 is the top.
    logic [WW-1:0] q[$];
    int            m_depth;
    bit            m_of, m_uf;
    bit            chk_en = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_depth();
`ifdef DSTACK_OCCUPANCY_EN
        return m_depth;
`else
        return 0;
`endif
    endfunction

    function automatic bit exp_flag(input bit f);
`ifdef DSTACK_OCCUPANCY_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        int k;
        if (reset) begin
            foreach (q[i]) q[i] = '0;
            m_depth = 0; m_of = 0; m_uf = 0;
        end else if (halt) begin
            m_of = 0; m_uf = 0;
        end else begin
            m_of = 0; m_uf = 0;
            k = int'(rotate_addr);
            case (movement)
                2'b01: begin
                    if (m_depth == DEPTH) m_of = 1; else m_depth++;
                    void'(q.pop_back());
                    q.push_front(next_top);
                end
                2'b10: begin
                    if (m_depth < 1) m_uf = 1;
                    m_depth = (m_depth >= 1) ? m_depth - 1 : 0;
                    void'(q.pop_front()); void'(q.pop_front());
                    q.push_front(next_top);
                    q.push_back('0);
                end
                2'b11: begin
                    if (m_depth < 2) m_uf = 1;
                    m_depth = (m_depth >= 2) ? m_depth - 2 : 0;
                    void'(q.pop_front()); void'(q.pop_front()); void'(q.pop_front());
                    q.push_front(next_top);
                    q.push_back('0); q.push_back('0);
                end
                default: begin
                    if (rotate) begin
                        if (k >= m_depth && (m_depth > 0 || k > 0)) m_uf = 1;
                        q.delete(k);
                        q.push_front(next_top);
                    end else begin
                        q[0] = next_top;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit h, input logic [1:0] mv,
                        input logic [WW-1:0] nt, input bit rot, input int k);
        reset = rst; halt = h; movement = mv; next_top = nt; rotate = rot;
        rotate_addr = AW'(k);
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic push(input logic [WW-1:0] v);
        step(0, 0, 2'b01, v, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("top", top, q[0]);
            chk("second", second, q[1]);
            chk("third", third, q[2]);
            chk("rotate_value", rotate_value, q[rotate_addr]);
            chk("depth", depth, exp_depth());
            chk("overflow", overflow, exp_flag(m_of));
            chk("underflow", underflow, exp_flag(m_uf));
        end
    end

    initial begin
        logic [1:0]    mv;
        logic [WW-1:0] nt;
        int            k;
        repeat (DEPTH) q.push_back('0);
        m_depth = 0; m_of = 0; m_uf = 0;

        step(1, 1, 2'b01, 32'h55, 0, 0);
        step(1, 0, 2'b00, 32'h0, 0, 0);
        chk_en = 1;
        chk("reset_top", top, 0);
        chk("reset_depth", depth, 0);
        chk("reset_flags", {overflow, underflow}, 0);

        // Three pushes, then pop, pop2 and an underflowing pop.
        push(32'hA); push(32'hB); push(32'hC);
        chk("t1_top", top, 32'hC);
        chk("t1_second", second, 32'hB);
        chk("t1_third", third, 32'hA);
        chk("t1_depth", depth, exp_depth() == 0 ? 0 : 3);
        step(0, 0, 2'b10, 32'hB, 0, 0);
        chk("t2_top", top, 32'hB);
        chk("t2_second", second, 32'hA);
        chk("t2_third", third, 32'h0);
        step(0, 0, 2'b11, 32'h0, 0, 0);
        chk("t2_pop2_uf", underflow, 0);
        chk("t2_pop2_depth", depth, 0);
        step(0, 0, 2'b10, 32'h0, 0, 0);
        chk("t2_pop_uf", underflow, exp_flag(1'b1));
        step(0, 0, 2'b00, 32'h0, 0, 0);
        chk("t2_uf_drop", underflow, 0);

        // Rotate k=3.
        step(1, 0, 2'b00, 0, 0, 0);
        for (int i = 1; i <= 5; i++) push(WW'(i));
        step(0, 0, 2'b00, q[3], 1, 3);
        chk("t3_top", top, 2);
        chk("t3_second", second, 5);
        chk("t3_third", third, 4);
        rotate_addr = AW'(3); #1 chk("t3_s3", rotate_value, 3);
        rotate_addr = AW'(4); #1 chk("t3_s4", rotate_value, 1);
        chk("t3_depth", depth, exp_depth() == 0 ? 0 : 5);

        // Copy k=2.
        step(1, 0, 2'b00, 0, 0, 0);
        for (int i = 1; i <= 3; i++) push(WW'(i));
        step(0, 0, 2'b01, q[2], 0, 2);
        chk("t4_top", top, 1);
        chk("t4_second", second, 3);
        chk("t4_third", third, 2);
        chk("t4_depth", depth, exp_depth() == 0 ? 0 : 4);

        // Fill past capacity.
        step(1, 0, 2'b00, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) push(WW'(i));
        chk("t5_no_of", overflow, 0);
        push(WW'(DEPTH + 1));
        chk("t5_of", overflow, exp_flag(1'b1));
        chk("t5_depth", depth, exp_depth() == 0 ? 0 : DEPTH);
        chk("t5_top", top, DEPTH + 1);
        rotate_addr = AW'(DEPTH - 1); #1 chk("t5_bottom", rotate_value, 2);

        // Halt freezes, reset wins over halt.
        step(0, 1, 2'b01, 32'hDEAD, 0, 0);
        step(0, 1, 2'b10, 32'hBEEF, 0, 0);
        chk("t6_halt_top", top, DEPTH + 1);
        chk("t6_halt_of", overflow, 0);
        step(1, 1, 2'b01, 32'hDEAD, 0, 0);
        chk("t6_rst_top", top, 0);
        chk("t6_rst_second", second, 0);
        chk("t6_rst_depth", depth, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            mv = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && mv != 2'b01) mv = (n % 200 < 120) ? 2'b01 : mv;
            k  = $urandom_range(0, DEPTH - 1);
            nt = $urandom;
            if ($urandom_range(0, 5) == 0) nt = q[k];
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, mv, nt,
                 $urandom_range(0, 3) == 0, k);
        end

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
